// File: rtl/hes_pkg.sv
// Shared types and defaults for the HES input feeder.
// Optional feature macro: HES_LEN_SUFFIX_EN (adds the SUFFIX state).
package hes_pkg;

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned LEN_W_DEF     = 32;
  localparam int unsigned LEN_BYTES_DEF = 4;

`ifdef HES_LEN_SUFFIX_EN
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StSuffix = 2'd2,
    StDone   = 2'd3
  } hes_state_e;
`else
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StDone   = 2'd3
  } hes_state_e;
`endif

endpackage

// File: rtl/hes_input_feeder_if.sv
// Byte input stream plus the F_dr/F_rtr feed toward the hash.
// master: the feeder side; slave: the file reader / hash side.
interface hes_input_feeder_if;

  logic [hes_pkg::BYTE_W-1:0] in_data;
  logic                       in_valid;
  logic                       in_last;
  logic                       in_ready;
  logic [hes_pkg::BYTE_W-1:0] M;
  logic                       F_dr;
  logic                       F_rtr;
  logic                       End_of_File;

  modport master (
    input  in_data, in_valid, in_last, F_rtr,
    output in_ready, M, F_dr, End_of_File
  );

  modport slave (
    output in_data, in_valid, in_last, F_rtr,
    input  in_ready, M, F_dr, End_of_File
  );

endinterface

// File: rtl/hes_skid_fifo.sv
// Two-entry byte FIFO with registered head; flush empties it in one cycle.
module hes_skid_fifo
  import hes_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        count
);

  logic [BYTE_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic              push;
  logic              pop;

  // A full FIFO can still take a byte when the head leaves in the same cycle.
  assign in_ready  = (count_q != 2'd2) | out_ready;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/hes_input_feeder.sv
// Feeds a byte stream into the HES hash over F_dr/F_rtr and counts message bytes.
// Optional feature macro: HES_LEN_SUFFIX_EN appends msg_len (LSB first, LEN_BYTES
// bytes) after the data and before End_of_File.
module hes_input_feeder
  import hes_pkg::*;
#(
  parameter int unsigned LEN_W     = LEN_W_DEF,
  parameter int unsigned LEN_BYTES = LEN_BYTES_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                empty_msg,
  hes_input_feeder_if.master  feed,
  output logic [LEN_W-1:0]    msg_len,
  output logic                len_ovf,
  output logic                busy
);

  hes_state_e        state_q;
  logic [LEN_W-1:0]  msg_len_q;
  logic              len_ovf_q;
  logic              eof_q;
  logic              last_seen_q;

  logic              fifo_in_ready;
  logic              fifo_valid;
  logic [BYTE_W-1:0] fifo_data;
  logic [1:0]        fifo_count;
  logic              accept;
  logic              suffix_phase;
  logic [BYTE_W-1:0] suffix_byte;

  // Input is throttled only by our own state and occupancy, never by F_rtr.
  assign feed.in_ready = (state_q == StActive) & (fifo_count != 2'd2) & fifo_in_ready &
                         ~last_seen_q;
  assign accept        = feed.in_valid & feed.in_ready;

  hes_skid_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (start),
    .in_data   (feed.in_data),
    .in_valid  (accept),
    .in_ready  (fifo_in_ready),
    .out_data  (fifo_data),
    .out_valid (fifo_valid),
    .out_ready (feed.F_rtr),
    .count     (fifo_count)
  );

`ifdef HES_LEN_SUFFIX_EN
  localparam int unsigned IdxW = (LEN_BYTES > 1) ? $clog2(LEN_BYTES) : 1;
  localparam int unsigned ExtW = (LEN_W > LEN_BYTES * 8) ? LEN_W : LEN_BYTES * 8;

  logic [IdxW-1:0] idx_q;
  logic [ExtW-1:0] len_ext;

  // Suffix bytes only go out once every data byte has left the FIFO.
  assign suffix_phase = (state_q == StSuffix) & ~fifo_valid;
  assign len_ext      = ExtW'(msg_len_q);
  assign suffix_byte  = len_ext[8*idx_q +: 8];
`else
  logic final_data;

  // Last data byte leaving: FIFO holds only it and no more input can arrive.
  assign final_data   = last_seen_q & (fifo_count == 2'd1) & fifo_valid & feed.F_rtr;
  assign suffix_phase = 1'b0;
  assign suffix_byte  = '0;
`endif

  assign feed.F_dr        = fifo_valid | suffix_phase;
  assign feed.M           = fifo_valid ? fifo_data : (suffix_phase ? suffix_byte : '0);
  assign feed.End_of_File = eof_q;
  assign msg_len          = msg_len_q;
  assign len_ovf          = len_ovf_q;
  assign busy             = ~((state_q == StIdle) | (state_q == StDone));

  // Control FSM, byte counter and registered status; start overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      msg_len_q   <= '0;
      len_ovf_q   <= 1'b0;
      eof_q       <= 1'b0;
      last_seen_q <= 1'b0;
`ifdef HES_LEN_SUFFIX_EN
      idx_q       <= '0;
`endif
    end else if (start) begin
      state_q     <= StActive;
      msg_len_q   <= '0;
      len_ovf_q   <= 1'b0;
      eof_q       <= 1'b0;
      last_seen_q <= 1'b0;
`ifdef HES_LEN_SUFFIX_EN
      idx_q       <= '0;
`endif
    end else begin
      if (accept) begin
        if (msg_len_q == '1) len_ovf_q <= 1'b1;
        else                 msg_len_q <= msg_len_q + LEN_W'(1);
        if (feed.in_last) last_seen_q <= 1'b1;
      end
      unique case (state_q)
        StActive: begin
`ifdef HES_LEN_SUFFIX_EN
          if (accept && feed.in_last) begin
            state_q <= StSuffix;
          end else
`else
          if (final_data) begin
            state_q <= StDone;
            eof_q   <= 1'b1;
          end else
`endif
          // A zero-length message is only legal before any byte was taken.
          if (empty_msg && !accept && (msg_len_q == '0) && !last_seen_q) begin
            state_q <= StDone;
            eof_q   <= 1'b1;
          end
        end
`ifdef HES_LEN_SUFFIX_EN
        StSuffix: begin
          if (suffix_phase && feed.F_rtr) begin
            if (idx_q == IdxW'(LEN_BYTES - 1)) begin
              state_q <= StDone;
              eof_q   <= 1'b1;
            end else begin
              idx_q <= idx_q + IdxW'(1);
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
